// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 key event path.
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  localparam int EV_W = $bits(ps2_event_t);

  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_EXT   = 8'hE0;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // A word ending in a prefix byte (or idle 0x00) is still mid-sequence.
  function automatic logic word_complete(input logic [7:0] last);
    return (last != PFX_BREAK) && (last != PFX_EXT) && (last != 8'h00);
  endfunction

  function automatic ps2_event_t decode_word(input logic [31:0] w);
    ps2_event_t ev;
    ev.code = w[7:0];
    ev.rel  = (w[15:8] == PFX_BREAK);
    ev.ext  = (w[15:8] == PFX_EXT) ||
              ((w[23:16] == PFX_EXT) && (w[15:8] == PFX_BREAK));
    return ev;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Power-of-two circular event queue; a push into a full queue is taken only
// when a pop frees a slot on the same edge, otherwise it is reported as drop.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ps2_event_t             push_data,
  input  logic                   pop,
  output ps2_event_t             head,
  output logic                   full,
  output logic                   empty,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is left unreset; head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_key_events.sv
// Turns the PS/2 scancode history word into queued make/break events and
// tracks live modifier state.
module ps2_key_events
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            kbd_word,
  output logic [EV_W-1:0]        ev_data,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   mod_shift,
  output logic                   mod_ctrl,
  output logic                   mod_alt
);

  logic [31:0] prev_q;
  logic        detect;
  ps2_event_t  ev_new;
  ps2_event_t  head;
  logic        empty;
  logic        full;
  logic        drop;
  logic        shift_q;
  logic        lctrl_q;
  logic        rctrl_q;
  logic        lalt_q;
  logic        ralt_q;

  assign detect = word_complete(kbd_word[7:0]) && (kbd_word != prev_q);
  assign ev_new = decode_word(kbd_word);

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (detect),
    .push_data (ev_new),
    .pop       (ev_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .drop      (drop),
    .count     (ev_count)
  );

  assign ev_data  = head;
  assign ev_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ovf    <= 1'b0;
    end else begin
      prev_q <= kbd_word;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Modifiers follow every detected key, including events the queue dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 1'b0;
      lctrl_q <= 1'b0;
      rctrl_q <= 1'b0;
      lalt_q  <= 1'b0;
      ralt_q  <= 1'b0;
    end else if (detect) begin
      if (!ev_new.ext && (ev_new.code == SC_LSHIFT || ev_new.code == SC_RSHIFT))
        shift_q <= !ev_new.rel;
      if (ev_new.code == SC_CTRL) begin
        if (ev_new.ext) rctrl_q <= !ev_new.rel;
        else            lctrl_q <= !ev_new.rel;
      end
      if (ev_new.code == SC_ALT) begin
        if (ev_new.ext) ralt_q <= !ev_new.rel;
        else            lalt_q <= !ev_new.rel;
      end
    end
  end

  assign mod_shift = shift_q;
  assign mod_ctrl  = lctrl_q | rctrl_q;
  assign mod_alt   = lalt_q | ralt_q;

endmodule

// File: tb/tb_ps2_key_events.sv
// Directed and randomized checks of ps2_key_events against a queue-based model.
module tb_ps2_key_events;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   kbd_word = '0;
  logic [9:0]    ev_data;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [CW-1:0] ev_count;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic          mod_shift, mod_ctrl, mod_alt;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [9:0]  m_q[$];
  logic [31:0] m_prev;
  logic        m_ovf, m_shift, m_lctrl, m_rctrl, m_lalt, m_ralt;

  ps2_key_events #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbd_word  (kbd_word),
    .ev_data   (ev_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .mod_alt   (mod_alt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_prev = '0; m_ovf = 0; m_shift = 0;
    m_lctrl = 0; m_rctrl = 0; m_lalt = 0; m_ralt = 0;
  endtask

  // Called at a negedge: apply inputs, advance the model, move to next negedge.
  task automatic step(input logic [31:0] w, input logic rdy, input logic clr);
    logic [7:0] b0, b1, b2;
    logic det, rel, ext, dropped;
    kbd_word = w; ev_ready = rdy; ovf_clr = clr;
    b0 = w[7:0]; b1 = w[15:8]; b2 = w[23:16];
    det = (b0 != 8'hF0) && (b0 != 8'hE0) && (b0 != 8'h00) && (w != m_prev);
    rel = (b1 == 8'hF0);
    ext = (b1 == 8'hE0) || (b2 == 8'hE0 && b1 == 8'hF0);
    dropped = 0;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (det) begin
      if (m_q.size() < DEPTH) m_q.push_back({ext, rel, b0});
      else dropped = 1;
      if (!ext && (b0 == 8'h12 || b0 == 8'h59)) m_shift = !rel;
      if (b0 == 8'h14) begin if (ext) m_rctrl = !rel; else m_lctrl = !rel; end
      if (b0 == 8'h11) begin if (ext) m_ralt = !rel; else m_lalt = !rel; end
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_prev = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; kbd_word = '0; ev_ready = 0; ovf_clr = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    kbd_word = 32'h0000_001C; ev_ready = 0;
    rst_n = 0;
    #2;
    n_total++;
    if ({ev_valid, ev_count, ovf, mod_shift, mod_ctrl, mod_alt} !== '0)
      $display("FAIL reset_outputs: got valid=%b cnt=%0d ovf=%b mods=%b%b%b expected all zero",
               ev_valid, ev_count, ovf, mod_shift, mod_ctrl, mod_alt);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ev_valid !== 1'b0 || ev_count !== '0)
      $display("FAIL reset_held: got valid=%b cnt=%0d expected 0/0", ev_valid, ev_count);
    else n_pass++;
    kbd_word = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_make_break();
    apply_reset();
    step(32'h1C, 0, 0);
    n_total++;
    if (ev_valid !== 1'b1 || ev_data !== 10'h01C)
      $display("FAIL make_event: got valid=%b data=%h expected 1/01c", ev_valid, ev_data);
    else n_pass++;
    step(32'hF0, 0, 0);
    n_total++;
    if (ev_count !== CW'(1))
      $display("FAIL break_prefix_no_event: got cnt=%0d expected 1", ev_count);
    else n_pass++;
    step(32'hF01C, 0, 0);
    n_total++;
    if (ev_count !== CW'(2) || ev_data !== 10'h01C)
      $display("FAIL break_count: got cnt=%0d head=%h expected 2/01c", ev_count, ev_data);
    else n_pass++;
    step(32'hF01C, 1, 0);
    n_total++;
    if (ev_count !== CW'(1) || ev_data !== 10'h11C)
      $display("FAIL break_event: got cnt=%0d head=%h expected 1/11c", ev_count, ev_data);
    else n_pass++;
    step(32'hF01C, 1, 0);
    step(32'hF01C, 1, 0);
    n_total++;
    if (ev_valid !== 1'b0 || ev_count !== '0)
      $display("FAIL pop_when_empty: got valid=%b cnt=%0d expected 0/0", ev_valid, ev_count);
    else n_pass++;
  endtask

  task automatic test_ext_break();
    logic [9:0] exp_ev[2];
    apply_reset();
    exp_ev[0] = 10'h275; exp_ev[1] = 10'h375;
    step(32'hE0, 0, 0);
    step(32'hE075, 0, 0);
    step(32'hE0F0, 0, 0);
    step(32'hE0F075, 0, 0);
    n_total++;
    if (ev_count !== CW'(2))
      $display("FAIL ext_count: got %0d expected 2", ev_count);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (ev_valid !== 1'b1 || ev_data !== exp_ev[i])
        $display("FAIL ext_event%0d: got valid=%b data=%h expected 1/%h", i, ev_valid, ev_data, exp_ev[i]);
      else n_pass++;
      step(32'hE0F075, 1, 0);
    end
  endtask

  task automatic test_typematic();
    apply_reset();
    for (int i = 0; i < 20; i++) step(32'h1C, 0, 0);
    n_total++;
    if (ev_count !== CW'(1) || ev_data !== 10'h01C)
      $display("FAIL typematic: got cnt=%0d head=%h expected 1/01c", ev_count, ev_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) step(32'h20 + i, 0, 0);
    n_total++;
    if (ev_count !== CW'(DEPTH) || ovf !== 1'b1)
      $display("FAIL overflow: got cnt=%0d ovf=%b expected %0d/1", ev_count, ovf, DEPTH);
    else n_pass++;
    step(32'h20 + DEPTH, 0, 1);
    n_total++;
    if (ovf !== 1'b0)
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (ev_valid !== 1'b1 || ev_data !== 10'(32'h20 + i))
        $display("FAIL overflow_order%0d: got valid=%b data=%h expected 1/%h", i, ev_valid, ev_data, 10'(32'h20 + i));
      else n_pass++;
      step(32'h20 + DEPTH, 1, 0);
    end
    n_total++;
    if (ev_valid !== 1'b0)
      $display("FAIL overflow_lost: got valid=%b expected 0 (last event dropped)", ev_valid);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(32'h30 + i, 0, 0);
    step(32'h3F, 1, 0);
    n_total++;
    if (ev_count !== CW'(DEPTH) || ovf !== 1'b0 || ev_data !== 10'h031)
      $display("FAIL full_push_pop: got cnt=%0d ovf=%b head=%h expected %0d/0/031", ev_count, ovf, ev_data, DEPTH);
    else n_pass++;
    for (int i = 1; i < DEPTH; i++) step(32'h3F, 1, 0);
    n_total++;
    if (ev_count !== CW'(1) || ev_data !== 10'h03F)
      $display("FAIL full_tail: got cnt=%0d head=%h expected 1/03f", ev_count, ev_data);
    else n_pass++;
  endtask

  task automatic test_modifiers();
    apply_reset();
    step(32'h12, 0, 0);
    n_total++;
    if ({mod_shift, mod_ctrl, mod_alt} !== 3'b100)
      $display("FAIL mod_shift_make: got %b%b%b expected 100", mod_shift, mod_ctrl, mod_alt);
    else n_pass++;
    step(32'hE014, 0, 0);
    n_total++;
    if ({mod_shift, mod_ctrl, mod_alt} !== 3'b110)
      $display("FAIL mod_ctrl_make: got %b%b%b expected 110", mod_shift, mod_ctrl, mod_alt);
    else n_pass++;
    step(32'hF012, 0, 0);
    n_total++;
    if ({mod_shift, mod_ctrl, mod_alt} !== 3'b010)
      $display("FAIL mod_shift_break: got %b%b%b expected 010", mod_shift, mod_ctrl, mod_alt);
    else n_pass++;
    rst_n = 0;
    #2;
    n_total++;
    if ({ev_valid, ev_count, ovf, mod_shift, mod_ctrl, mod_alt} !== '0)
      $display("FAIL mod_reset: got valid=%b cnt=%0d ovf=%b mods=%b%b%b expected all zero",
               ev_valid, ev_count, ovf, mod_shift, mod_ctrl, mod_alt);
    else n_pass++;
    kbd_word = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [7:0] pick_b0();
    case ($urandom_range(0, 8))
      0: return 8'hF0;
      1: return 8'hE0;
      2: return 8'h00;
      3: return 8'h12;
      4: return 8'h59;
      5: return 8'h14;
      6: return 8'h11;
      7: return 8'h1C;
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] w;
    logic [7:0]  b1, b2;
    int errs;
    apply_reset();
    w = '0;
    for (int i = 0; i < 600; i++) begin
      errs = 0;
      n_total++;
      if (ev_valid !== (m_q.size() > 0) || ev_count !== CW'(m_q.size()) || ovf !== m_ovf)
        $display("FAIL rand_status@%0d: got valid=%b cnt=%0d ovf=%b expected %b/%0d/%b",
                 i, ev_valid, ev_count, ovf, m_q.size() > 0, m_q.size(), m_ovf);
      else n_pass++;
      n_total++;
      if ({mod_shift, mod_ctrl, mod_alt} !== {m_shift, m_lctrl | m_rctrl, m_lalt | m_ralt})
        $display("FAIL rand_mods@%0d: got %b%b%b expected %b%b%b", i, mod_shift, mod_ctrl, mod_alt,
                 m_shift, m_lctrl | m_rctrl, m_lalt | m_ralt);
      else n_pass++;
      if (m_q.size() > 0) begin
        n_total++;
        if (ev_data !== m_q[0])
          $display("FAIL rand_head@%0d: got %h expected %h", i, ev_data, m_q[0]);
        else n_pass++;
      end
      if ($urandom_range(0, 9) >= 3) begin
        case ($urandom_range(0, 3))
          0: b1 = 8'hF0;
          1: b1 = 8'hE0;
          2: b1 = 8'h00;
          default: b1 = 8'($urandom);
        endcase
        b2 = ($urandom_range(0, 2) == 0) ? 8'hE0 : 8'($urandom);
        w = {8'($urandom), b2, b1, pick_b0()};
      end
      step(w, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_make_break();
    test_ext_break();
    test_typematic();
    test_overflow();
    test_full_push_pop();
    test_modifiers();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
